// File: rtl/afifo_rd_arbiter.sv
// afifo_rd_arbiter: round-robin burst arbiter sharing one async FIFO read port among N consumers
module afifo_rd_arbiter #(
  parameter int N = 4,
  parameter int DW = 8,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          rempty,
  input  logic [DW-1:0] rdata,
  output logic          rinc,
  output logic [N-1:0]  gnt,
  output logic [DW-1:0] dout,
  output logic [N-1:0]  dout_vld,
  output logic          busy
);
  localparam int CW = BURST > 1 ? $clog2(BURST) : 1;
  localparam int IW = $clog2(N);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [CW-1:0] beat_cnt;
  logic [IW-1:0] last, owner, pick, idx;
  logic own_req, last_beat;
  // gnt is zero outside GRANT, so owner request alone qualifies the pop
  assign own_req = |(gnt & req);
  assign rinc = rst_n & own_req & ~rempty;
  assign last_beat = beat_cnt == CW'(BURST - 1);
  // descending scan so the requester nearest after last is assigned last and wins
  always_comb begin
    pick = last;
    idx = last;
    for (int i = N; i >= 1; i--) begin
      idx = IW'((int'(last) + i) % N);
      if (req[idx]) pick = idx;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= '0;
      dout <= '0;
      dout_vld <= '0;
      busy <= 1'b0;
      beat_cnt <= '0;
      last <= IW'(N - 1);
      owner <= '0;
    end else begin
      dout_vld <= rinc ? gnt : '0;
      if (rinc) dout <= rdata;
      case (state)
        IDLE: if (|req) begin
          state <= GRANT;
          busy <= 1'b1;
          gnt <= N'(1) << pick;
          owner <= pick;
          beat_cnt <= '0;
        end
        GRANT: if (!own_req || (rinc && last_beat)) begin
          state <= IDLE;
          busy <= 1'b0;
          gnt <= '0;
          last <= owner;
        end else if (rinc) beat_cnt <= beat_cnt + CW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule
